// File: rtl/ram_bus_pkg.sv
// ram_bus_pkg
// Shared definitions for the single_port_sync_ram bus initiator:
//   - state_t : burst sequencer states
//   - DEF_*   : default bus geometry (13-bit address, 8-bit data, 5-bit length)
//   - cmd_t   : one burst command {we, addr, len} at the default geometry
package ram_bus_pkg;

  localparam int DEF_ADDR_WIDTH = 13;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LEN_WIDTH  = 5;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_DATA,
    TURN
  } state_t;

  typedef struct packed {
    logic                      we;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_LEN_WIDTH-1:0]  len;
  } cmd_t;

endpackage

// File: rtl/ram_bus_tristate.sv
// ram_bus_tristate
// Master-side driver for the shared RAM data bus. The drive enable and the
// outgoing word are registered together, so the bus is driven exactly in the
// cycles where the registered ram_we is high and is released otherwise.
// Ports:
//   clk, rstn   clock / asynchronous active-low reset (reset releases the bus)
//   drive_next  drive the bus in the next cycle (same value as next ram_we)
//   data_next   word to place on the bus in the next cycle
//   bus_in      current value seen on the bus (read path)
//   ram_data    shared bidirectional RAM data bus
module ram_bus_tristate
  import ram_bus_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  drive_next,
  input  logic [DATA_WIDTH-1:0] data_next,
  output logic [DATA_WIDTH-1:0] bus_in,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  logic                  drive_q;
  logic [DATA_WIDTH-1:0] data_q;

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of its peers; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drive_q <= 1'b0;
      data_q  <= '0;
    end else begin
      drive_q <= drive_next;
      if (drive_next) begin
        data_q <= data_next;
      end
    end
  end

  assign ram_data = drive_q ? data_q : 'z;
  assign bus_in   = ram_data;

endmodule

// File: rtl/ram_burst_master.sv
// ram_burst_master
// Burst initiator for the single_port_sync_ram bus (cs/we/oe, shared data).
// A client issues {we, addr, len} over req_valid/req_ready; the master then
// runs len RAM cycles at an auto-incrementing (wrapping) address, taking write
// words over wr_valid/wr_ready or returning read words on rd_valid/rd_data.
// done pulses once per accepted command (len=0 included). All RAM-side
// outputs are registered.
//
// Ports:
//   clk, rstn                  clock / asynchronous active-low reset
//   req_valid/req_ready        command handshake (req_ready = state is IDLE)
//   req_we, req_addr, req_len  command: direction, base address, word count
//   wr_valid/wr_ready/wr_data  write word stream (wr_ready = state is WR)
//   rd_valid/rd_data           read word stream, one-cycle pulse, no backpressure
//   done                       one-cycle pulse marking the end of a burst
//   ram_cs/ram_we/ram_oe       RAM controls
//   ram_addr                   RAM address
//   ram_data                   shared data bus, driven only while ram_we=1
//
// Build option: defining RAM_BURST_MASTER_TURNAROUND_EN inserts one dead TURN
// cycle after every read burst before the master returns to IDLE.
//
// Read timing: RD_ADDR presents the address (RAM captures the word on the
// closing edge), RD_DATA holds cs/oe while the RAM drives the bus and the word
// is sampled on the closing edge, so rd_valid follows one cycle later.
module ram_burst_master
  import ram_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_next;
  logic [LEN_WIDTH-1:0]  remaining, remaining_next;
  logic                  cs_next, we_next, oe_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  rd_valid_next;
  logic [DATA_WIDTH-1:0] rd_data_next;
  logic                  done_next;
  logic [DATA_WIDTH-1:0] bus_in;
  logic                  last_word;

  assign req_ready = (state == IDLE);
  assign wr_ready  = (state == WR);
  assign last_word = (remaining == LEN_WIDTH'(1));

  // Next-state and next-output logic. RAM outputs are computed per transition
  // so that the registered cs/we/oe/addr describe the cycle being entered.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_next     = state;
    cur_addr_next  = cur_addr;
    remaining_next = remaining;
    cs_next        = 1'b0;
    we_next        = 1'b0;
    oe_next        = 1'b0;
    addr_next      = ram_addr;
    rd_valid_next  = 1'b0;
    rd_data_next   = rd_data;
    done_next      = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          cur_addr_next  = req_addr;
          remaining_next = req_len;
          if (req_len == '0) begin
            done_next = 1'b1;
          end else if (req_we) begin
            state_next = WR;
          end else begin
            state_next = RD_ADDR;
            cs_next    = 1'b1;
            oe_next    = 1'b1;
            addr_next  = req_addr;
          end
        end
      end

      WR: begin
        // A missing wr_valid leaves cs/we at their defaults: a stall cycle.
        if (wr_valid) begin
          cs_next        = 1'b1;
          we_next        = 1'b1;
          addr_next      = cur_addr;
          cur_addr_next  = cur_addr + ADDR_WIDTH'(1);
          remaining_next = remaining - LEN_WIDTH'(1);
          if (last_word) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end

      RD_ADDR: begin
        state_next = RD_DATA;
        cs_next    = 1'b1;
        oe_next    = 1'b1;
      end

      RD_DATA: begin
        rd_valid_next  = 1'b1;
        rd_data_next   = bus_in;
        cur_addr_next  = cur_addr + ADDR_WIDTH'(1);
        remaining_next = remaining - LEN_WIDTH'(1);
        if (last_word) begin
          done_next  = 1'b1;
`ifdef RAM_BURST_MASTER_TURNAROUND_EN
          state_next = TURN;
`else
          state_next = IDLE;
`endif
        end else begin
          state_next = RD_ADDR;
          cs_next    = 1'b1;
          oe_next    = 1'b1;
          addr_next  = cur_addr + ADDR_WIDTH'(1);
        end
      end

      TURN: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      ram_addr  <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      cur_addr  <= cur_addr_next;
      remaining <= remaining_next;
      ram_cs    <= cs_next;
      ram_we    <= we_next;
      ram_oe    <= oe_next;
      ram_addr  <= addr_next;
      rd_valid  <= rd_valid_next;
      rd_data   <= rd_data_next;
      done      <= done_next;
    end
  end

  // The bus driver enable shares its next value with ram_we, so the master
  // drives ram_data exactly while ram_we is high.
  ram_bus_tristate #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_tristate (
    .clk       (clk),
    .rstn      (rstn),
    .drive_next(we_next),
    .data_next (wr_data),
    .bus_in    (bus_in),
    .ram_data  (ram_data)
  );

endmodule

// File: tb/tb_ram_burst_master.sv
// tb_ram_burst_master
// Self-checking bench for ram_burst_master. A behavioural sync RAM sits on the
// bus; a reference memory image predicts every RAM write (address, data) and
// every read word. Stimulus tasks push expectations into queues; a monitor on
// the falling clock edge pops and compares whenever the DUT shows a RAM write
// or an rd_valid pulse. Driver tasks also check cycle-exact timing.
module tb_ram_burst_master;
  import ram_bus_pkg::*;

  localparam int AW = DEF_ADDR_WIDTH;
  localparam int DW = DEF_DATA_WIDTH;
  localparam int LW = DEF_LEN_WIDTH;
`ifdef RAM_BURST_MASTER_TURNAROUND_EN
  localparam bit TURN_EN = 1'b1;
`else
  localparam bit TURN_EN = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          req_ready, wr_ready, rd_valid, done;
  logic          ram_cs, ram_we, ram_oe;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;

  always #5 clk = ~clk;

  ram_burst_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_len  (req_len),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .done     (done),
    .ram_cs   (ram_cs),
    .ram_we   (ram_we),
    .ram_oe   (ram_oe),
    .ram_addr (ram_addr),
    .ram_data (ram_data)
  );

  // Behavioural single_port_sync_ram: write on cs&we, capture on cs&!we,
  // drive the bus while cs&oe&!we.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
    if (ram_cs && !ram_we) ram_q <= mem[ram_addr];
  end
  assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_q : 'z;

  // Reference model and scoreboard state.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  wr_t           exp_wr [$];
  logic [DW-1:0] exp_rd [$];
  logic [DW-1:0] wq [$];
  int vectors = 0;
  int miscompares = 0;
  int done_seen = 0;
  int done_exp = 0;
  int cs_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] wrap(input int base, input int off);
    return AW'((base + off) % (1 << AW));
  endfunction

  // Monitor: consumes expectations whenever the DUT presents a result.
  always @(negedge clk) begin
    if (rstn) begin
      if (ram_cs) cs_cycles++;
      if (ram_we) check("we_oe_exclusive", {31'b0, ram_oe}, 32'd0);
      if (ram_cs && ram_we) begin
        if (exp_wr.size() == 0) begin
          flag("unexpected_ram_write");
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("ram_write_addr", 32'(ram_addr), 32'(w.addr));
          check("ram_write_data", 32'(ram_data), 32'(w.data));
        end
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) begin
          flag("unexpected_rd_valid");
        end else begin
          logic [DW-1:0] e;
          e = exp_rd.pop_front();
          check("rd_data", 32'(rd_data), 32'(e));
        end
      end
      if (done) done_seen++;
    end
  end

  // Present a command; returns one step after the accepting edge.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input int len);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_len   = LW'(len);
    while (!req_ready && n < 50) begin
      tick;
      n++;
    end
    if (!req_ready) flag("req_ready_timeout");
    tick;
    req_valid = 1'b0;
  endtask

  task automatic len0_checks;
    int cs_before = cs_cycles;
    check("len0_done", {31'b0, done}, 32'd1);
    check("len0_stays_idle", {31'b0, req_ready}, 32'd1);
    tick;
    check("len0_done_pulse", {31'b0, done}, 32'd0);
    tick;
    check("len0_no_ram_cycle", 32'(cs_cycles), 32'(cs_before));
    done_exp++;
  endtask

  // Write burst of the words in wq. Stall stall_n cycles before word stall_at;
  // with rnd set, random short stalls may precede any word.
  task automatic do_write(input logic [AW-1:0] addr, input int len,
                          input int stall_at, input int stall_n, input bit rnd);
    for (int i = 0; i < len; i++) begin
      wr_t w;
      w.addr = wrap(int'(addr), i);
      w.data = wq[i];
      exp_wr.push_back(w);
      ref_mem[w.addr] = wq[i];
    end
    issue(1'b1, addr, len);
    if (len == 0) begin
      len0_checks();
      return;
    end
    for (int i = 0; i < len; i++) begin
      int ns;
      ns = (i == stall_at) ? stall_n : 0;
      if (rnd && $urandom_range(0, 3) == 0) ns = int'($urandom_range(1, 2));
      wr_valid = 1'b0;
      for (int s = 0; s < ns; s++) begin
        tick;
        check("stall_cs_low", {31'b0, ram_cs}, 32'd0);
      end
      check("wr_ready", {31'b0, wr_ready}, 32'd1);
      wr_valid = 1'b1;
      wr_data  = wq[i];
      tick;
      check("wr_cycle_cs", {31'b0, ram_cs}, 32'd1);
      check("wr_cycle_oe_low", {31'b0, ram_oe}, 32'd0);
      check("wr_done_timing", {31'b0, done}, {31'b0, i == len - 1});
    end
    wr_valid = 1'b0;
    wr_data  = '0;
    done_exp++;
  endtask

  // Read burst: rd_valid expected 2,4,..,2*len edges after the accept edge,
  // done together with the last word.
  task automatic do_read(input logic [AW-1:0] addr, input int len);
    for (int i = 0; i < len; i++) exp_rd.push_back(ref_mem[wrap(int'(addr), i)]);
    issue(1'b0, addr, len);
    if (len == 0) begin
      len0_checks();
      return;
    end
    for (int c = 1; c <= 2 * len + 1; c++) begin
      tick;
      check("rd_valid_timing", {31'b0, rd_valid}, {31'b0, (c % 2 == 0) && (c <= 2 * len)});
      check("rd_done_timing", {31'b0, done}, {31'b0, c == 2 * len});
      if (c == 2 * len) check("ready_after_read", {31'b0, req_ready}, {31'b0, !TURN_EN});
    end
    done_exp++;
  endtask

  // Read of one word followed by a write presented as early as possible;
  // measures dead cycles between the last oe=1 and the first we=1.
  task automatic turnaround_test(input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                                 input logic [DW-1:0] wd);
    int last_oe = -1;
    int first_we = -1;
    wr_t w;
    exp_rd.push_back(ref_mem[ra]);
    w.addr = wa;
    w.data = wd;
    exp_wr.push_back(w);
    ref_mem[wa] = wd;
    issue(1'b0, ra, 1);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = wa;
    req_len   = LW'(1);
    wr_valid  = 1'b1;
    wr_data   = wd;
    for (int c = 0; c < 12 && first_we < 0; c++) begin
      if (ram_oe) last_oe = c;
      if (ram_we) first_we = c;
      if (req_valid && req_ready) begin
        tick;
        req_valid = 1'b0;
      end else begin
        tick;
      end
    end
    req_valid = 1'b0;
    wr_valid  = 1'b0;
    if (first_we < 0 || last_oe < 0) begin
      flag("turnaround_no_activity");
    end else begin
      // IDLE cycle + WR handshake cycle, plus TURN when enabled.
      check("turnaround_gap", 32'(first_we - last_oe - 1), TURN_EN ? 32'd3 : 32'd2);
    end
    repeat (3) tick;
    done_exp += 2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] last_wa;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end

    // Reset state.
    #2;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
    check("rst_cs_we_oe", {29'b0, ram_cs, ram_we, ram_oe}, 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_rd_valid_done", {30'b0, rd_valid, done}, 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick;

    // Write 0x10..0x1F at 0, then read it back.
    wq.delete();
    for (int i = 0; i < 16; i++) wq.push_back(DW'(8'h10 + i));
    do_write('0, 16, -1, 0, 1'b0);
    do_read('0, 16);

    // Address wrap.
    wq.delete();
    wq.push_back(8'hA1);
    wq.push_back(8'hA2);
    wq.push_back(8'hA3);
    do_write(AW'(13'h1FFE), 3, -1, 0, 1'b0);
    do_read(AW'(13'h1FFE), 3);

    // Three-cycle stall mid-burst.
    wq.delete();
    for (int i = 0; i < 8; i++) wq.push_back(DW'($urandom));
    do_write(AW'(13'h100), 8, 4, 3, 1'b0);
    do_read(AW'(13'h100), 8);

    // Zero-length commands.
    do_write(AW'(13'h055), 0, -1, 0, 1'b0);
    do_read(AW'(13'h055), 0);

    // Reset during read word 5 of an 8-word read at 0.
    for (int i = 0; i < 8; i++) exp_rd.push_back(ref_mem[i]);
    issue(1'b0, '0, 8);
    repeat (9) tick;
    check("pre_reset_cs_oe", {30'b0, ram_cs, ram_oe}, 32'd3);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_cs_we_oe", {29'b0, ram_cs, ram_we, ram_oe}, 32'd0);
    check("async_rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("async_rst_done", {31'b0, done}, 32'd0);
    check("words_before_reset", 32'(exp_rd.size()), 32'd4);
    exp_rd.delete();
    @(negedge clk);
    rstn = 1'b1;
    tick;
    check("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("post_rst_no_done", {31'b0, done}, 32'd0);

    // Read-to-write bus turnaround.
    turnaround_test(AW'(13'h003), AW'(13'h200), 8'h5C);

    // Randomized bursts; reads land near the last written region.
    last_wa = '0;
    for (int n = 0; n < 24; n++) begin
      cmd_t c;
      c.we  = 1'($urandom_range(0, 1));
      c.len = LW'($urandom_range(0, (1 << LW) - 1));
      if (c.we) begin
        c.addr  = AW'($urandom_range(0, (1 << AW) - 1));
        last_wa = c.addr;
        wq.delete();
        for (int i = 0; i < int'(c.len); i++) wq.push_back(DW'($urandom));
        do_write(c.addr, int'(c.len), -1, 0, 1'b1);
      end else begin
        c.addr = wrap(int'(last_wa), int'($urandom_range(0, 8)));
        do_read(c.addr, int'(c.len));
      end
    end

    repeat (4) tick;
    check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    check("done_count", 32'(done_seen), 32'(done_exp));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
